// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive paths.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   function automatic int clks_per_bit(input int freq, input int baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO for the UART transmit path; head entry is readable without a pop.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = UART_DATA_BITS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             do_push;
   logic             do_pop;

   // A push is refused when full even if a pop happens on the same edge.
   assign full     = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty    = (count_reg == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr_reg];
   assign count    = count_reg;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop frame serialiser.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int BAUD_RATE    = 9600,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE),
   parameter int FIFO_DEPTH   = 8,
   parameter bit PARITY_EN    = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [UART_DATA_BITS-1:0]   tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        tx,
   output logic                        tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(UART_DATA_BITS);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

   uart_state_t               state_reg, state_next;
   logic [CNT_W-1:0]          baud_cnt_reg, baud_cnt_next;
   logic [BIT_W-1:0]          bit_idx_reg, bit_idx_next;
   logic [UART_DATA_BITS-1:0] shreg_reg, shreg_next;
   logic                      tx_reg, tx_next;
   logic                      baud_done;
   logic                      fifo_pop;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [UART_DATA_BITS-1:0] fifo_head;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tx_valid),
      .push_data (tx_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign tx_ready  = !fifo_full;
   assign tx_busy   = (state_reg != ST_IDLE) || !fifo_empty;
   assign tx        = tx_reg;
   assign baud_done = (baud_cnt_reg == BAUD_LAST);

   always_comb begin
      state_next    = state_reg;
      baud_cnt_next = '0;
      bit_idx_next  = bit_idx_reg;
      shreg_next    = shreg_reg;
      fifo_pop      = 1'b0;
      tx_next       = 1'b1;

      if (state_reg != ST_IDLE && !baud_done) begin
         baud_cnt_next = baud_cnt_reg + 1'b1;
      end

      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               shreg_next = fifo_head;
               state_next = ST_START;
            end
         end
         ST_START: begin
            if (baud_done) begin
               state_next   = ST_DATA;
               bit_idx_next = '0;
            end
         end
         ST_DATA: begin
            if (baud_done) begin
               if (bit_idx_reg == BIT_LAST) begin
                  state_next = PARITY_EN ? ST_PARITY : ST_STOP;
               end else begin
                  bit_idx_next = bit_idx_reg + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (baud_done) begin
               state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            // Chain straight into the next start bit so queued frames leave no gap.
            if (baud_done) begin
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  shreg_next = fifo_head;
                  state_next = ST_START;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Line level is computed from the next state so tx leaves a flop.
      case (state_next)
         ST_START:  tx_next = 1'b0;
         ST_DATA:   tx_next = shreg_next[bit_idx_next];
         ST_PARITY: tx_next = ^shreg_next;
         default:   tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= ST_IDLE;
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         shreg_reg    <= '0;
         tx_reg       <= 1'b1;
      end else begin
         state_reg    <= state_next;
         baud_cnt_reg <= baud_cnt_next;
         bit_idx_reg  <= bit_idx_next;
         shreg_reg    <= shreg_next;
         tx_reg       <= tx_next;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (no parity / even parity) against a frame-schedule model.
module tb_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   typedef struct {
      int         inst;
      logic [7:0] data;
      int         start;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] valid_w;
   logic [7:0] data0, data1;
   logic       tx0, tx1, ready0, ready1, busy0, busy1;
   logic [2:0] count0, count1;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int line_free [2];
   ent_t sched[$];
   ent_t exp_q[$];

   bit         mon_act   [2];
   int         mon_start [2];
   logic       mon_slot  [2];
   logic [10:0] mon_bits [2];
   ent_t       mon_cur   [2];

   uart_tx #(
      .CLK_FREQ     (50_000_000),
      .BAUD_RATE    (9600),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .PARITY_EN    (1'b0)
   ) dut0 (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (data0),
      .tx_valid   (valid_w[0]),
      .tx_ready   (ready0),
      .tx         (tx0),
      .tx_busy    (busy0),
      .fifo_count (count0)
   );

   uart_tx #(
      .CLK_FREQ     (50_000_000),
      .BAUD_RATE    (9600),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .PARITY_EN    (1'b1)
   ) dut1 (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (data1),
      .tx_valid   (valid_w[1]),
      .tx_ready   (ready1),
      .tx         (tx1),
      .tx_busy    (busy1),
      .fifo_count (count1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int frame_len(int idx);
      return (10 + idx) * CPB;
   endfunction

   // Bytes accepted but not yet started are what the FIFO holds.
   function automatic int occ(int idx, int t);
      int n = 0;
      foreach (sched[i]) if (sched[i].inst == idx && sched[i].start > t) n++;
      return n;
   endfunction

   function automatic bit busy_m(int idx, int t);
      foreach (sched[i]) if (sched[i].inst == idx && sched[i].start + frame_len(idx) > t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(string name, int act, int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference model: a byte offered at edge k+1 is accepted if fewer than DEPTH are waiting;
   // it starts one edge later or as soon as the previous frame on that line ends.
   initial forever begin
      @(posedge clk);
      if (rst) begin
         for (int i = sched.size() - 1; i >= 0; i--)
            if (sched[i].start + frame_len(sched[i].inst) <= cyc) sched.delete(i);
         for (int idx = 0; idx < 2; idx++) begin
            if (valid_w[idx] && occ(idx, cyc) < DEPTH) begin
               ent_t e;
               e.inst  = idx;
               e.data  = (idx == 0) ? data0 : data1;
               e.start = (cyc + 2 > line_free[idx]) ? cyc + 2 : line_free[idx];
               line_free[idx] = e.start + frame_len(idx);
               sched.push_back(e);
               exp_q.push_back(e);
            end
         end
      end
   end

   task automatic monitor_step(int idx);
      logic line, bsy, rdy;
      int   cnt, o, f;
      logic [7:0] d;
      line = (idx == 0) ? tx0 : tx1;
      bsy  = (idx == 0) ? busy0 : busy1;
      rdy  = (idx == 0) ? ready0 : ready1;
      cnt  = (idx == 0) ? int'(count0) : int'(count1);
      if (!rst) begin
         mon_act[idx] = 1'b0;
         check("reset_tx", int'(line), 1);
         check("reset_busy", int'(bsy), 0);
         check("reset_count", cnt, 0);
      end else begin
         check("ready", int'(rdy), int'(occ(idx, cyc) < DEPTH));
         check("count", cnt, occ(idx, cyc));
         check("busy", int'(bsy), int'(busy_m(idx, cyc)));
         if (!mon_act[idx] && line == 1'b0) begin
            f = -1;
            foreach (exp_q[i]) if (f < 0 && exp_q[i].inst == idx) f = i;
            mon_act[idx]   = 1'b1;
            mon_start[idx] = cyc;
            mon_bits[idx]  = '0;
            if (f < 0) begin
               check("unexpected_frame", 1, 0);
               mon_cur[idx].data  = '0;
               mon_cur[idx].start = cyc;
            end else begin
               mon_cur[idx] = exp_q[f];
               exp_q.delete(f);
               check("start_cycle", cyc, mon_cur[idx].start);
            end
         end
         if (mon_act[idx]) begin
            o = cyc - mon_start[idx];
            if (o % CPB == 0) mon_slot[idx] = line;
            else check("bit_stable", int'(line), int'(mon_slot[idx]));
            if (o % CPB == CPB / 2) mon_bits[idx][o / CPB] = line;
            if (o == frame_len(idx) - 1) begin
               mon_act[idx] = 1'b0;
               for (int b = 0; b < 8; b++) d[b] = mon_bits[idx][1 + b];
               check("start_bit", int'(mon_bits[idx][0]), 0);
               check("data", int'(d), int'(mon_cur[idx].data));
               if (idx == 1) check("parity", int'(mon_bits[idx][9]), $countones(mon_cur[idx].data) % 2);
               check("stop_bit", int'(mon_bits[idx][9 + idx]), 1);
               $display("frame dut%0d data=%02h start=%0d", idx, d, mon_start[idx]);
            end
         end
      end
   endtask

   initial forever begin
      @(negedge clk);
      for (int idx = 0; idx < 2; idx++) monitor_step(idx);
   end

   task automatic put(int idx, logic [7:0] d);
      valid_w[idx] = 1'b1;
      if (idx == 0) data0 = d; else data1 = d;
      @(negedge clk);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) begin
         valid_w = '0;
         data0   = 8'($urandom);
         data1   = 8'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic wait_idle(int budget);
      int n = 0;
      valid_w = '0;
      @(negedge clk);
      while ((busy_m(0, cyc) || busy_m(1, cyc)) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", n);
      end
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k, ystart, p;
      valid_w = '0;
      data0 = '0;
      data1 = '0;
      line_free[0] = 0;
      line_free[1] = 0;
      rst = 1'b1;
      #1 rst = 1'b0;

      // Reset held while upstream offers bytes: nothing may be accepted.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         valid_w = i[0] ? 2'b11 : 2'b00;
         data0 = 8'($urandom);
         data1 = 8'($urandom);
      end
      @(negedge clk);
      valid_w = '0;
      rst = 1'b1;
      idle(2);

      // Single byte, no parity.
      put(0, 8'hA5);
      wait_idle(200);

      // Even parity: odd-weight and zero bytes.
      put(1, 8'h07);
      wait_idle(200);
      put(1, 8'h00);
      wait_idle(200);

      // Burst of five fills the FIFO; a sixth offer is refused.
      for (int i = 0; i < 5; i++) put(0, 8'(17 * (i + 1)));
      valid_w[0] = 1'b1;
      data0 = 8'h66;
      check("full_ready", int'(ready0), 0);
      check("full_count", int'(count0), DEPTH);
      @(negedge clk);
      wait_idle(600);

      // Push lands on the same edge the STOP bit ends and pops the single queued byte.
      k = cyc;
      put(0, 8'hE7);
      put(0, 8'h18);
      ystart = k + 2 + frame_len(0);
      while (cyc < ystart - 1) idle(1);
      put(0, 8'h9C);
      check("pushpop_count", int'(count0), 1);
      wait_idle(300);

      // Asynchronous reset in the middle of a data bit with two bytes queued.
      k = cyc;
      put(0, 8'h3C);
      put(0, 8'h5A);
      put(0, 8'hC3);
      while (cyc < k + 15) idle(1);
      #2;
      valid_w = '0;
      rst = 1'b0;
      sched.delete();
      exp_q.delete();
      line_free[0] = 0;
      line_free[1] = 0;
      #1;
      check("abort_tx", int'(tx0), 1);
      check("abort_count", int'(count0), 0);
      check("abort_busy", int'(busy0), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      idle(2);
      put(0, 8'h81);
      wait_idle(200);

      // Randomised traffic alternating sparse and dense phases on both lines.
      for (int c = 0; c < 2000; c++) begin
         p = ((c / 250) % 2 == 1) ? 70 : 8;
         for (int idx = 0; idx < 2; idx++) valid_w[idx] = ($urandom_range(0, 99) < p);
         data0 = 8'($urandom);
         data1 = 8'($urandom);
         @(negedge clk);
      end
      wait_idle(2000);

      check("leftover_frames", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
